// File: rtl/mux21_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream consumer.
// The master side is the requesters plus the consumer; the slave side is the arbiter.
interface mux21_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req_0;
  logic [WIDTH-1:0] datain_0;
  logic             ack_0;
  logic             req_1;
  logic [WIDTH-1:0] datain_1;
  logic             ack_1;
  logic             select;
  logic [WIDTH-1:0] out;
  logic             out_src;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output req_0, datain_0, req_1, datain_1, out_ready,
    input  ack_0, ack_1, select, out, out_src, out_valid
  );

  modport slave (
    input  req_0, datain_0, req_1, datain_1, out_ready,
    output ack_0, ack_1, select, out, out_src, out_valid
  );
endinterface

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter for the shared 2:1 data mux, capping grants at BURST_MAX beats.
// Define MUX21_ARB_FIXED_PRIO_EN to make IDLE ties always favour requester 0.
module mux21_arbiter #(
  parameter int WIDTH     = 4,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mux21_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_BEAT_LAST = CNT_W'(BURST_MAX - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_out_src;
  logic             r_out_valid;
  logic             r_last;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_space;
  logic             w_ack_0;
  logic             w_ack_1;
  logic             w_ack;
  logic             w_select;
  logic [WIDTH-1:0] w_mux_data;
  logic             w_tie_grant_1;
  logic             w_beat_last;

  // A slot is free when empty or when the held word leaves this cycle.
  assign w_space     = !r_out_valid || bus.out_ready;
  assign w_ack_0     = !i_rst && (r_state == GRANT0) && bus.req_0 && w_space;
  assign w_ack_1     = !i_rst && (r_state == GRANT1) && bus.req_1 && w_space;
  assign w_ack       = w_ack_0 || w_ack_1;
  assign w_select    = (r_state == GRANT1);
  assign w_mux_data  = w_select ? bus.datain_1 : bus.datain_0;
  assign w_beat_last = (r_beat_cnt == LP_BEAT_LAST);

`ifdef MUX21_ARB_FIXED_PRIO_EN
  assign w_tie_grant_1 = 1'b0;
`else
  assign w_tie_grant_1 = !r_last;
`endif

  assign bus.ack_0     = w_ack_0;
  assign bus.ack_1     = w_ack_1;
  assign bus.select    = w_select;
  assign bus.out       = r_out;
  assign bus.out_src   = r_out_src;
  assign bus.out_valid = r_out_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_out_src   <= 1'b0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b1;
      r_beat_cnt  <= '0;
    end else begin
      // Output stage: a load wins over a consume, keeping back-to-back throughput.
      if (w_ack) begin
        r_out       <= w_mux_data;
        r_out_src   <= w_ack_1;
        r_out_valid <= 1'b1;
        r_last      <= w_ack_1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_beat_cnt <= '0;
          if (bus.req_0 && bus.req_1) begin
            r_state <= w_tie_grant_1 ? GRANT1 : GRANT0;
          end else if (bus.req_0) begin
            r_state <= GRANT0;
          end else if (bus.req_1) begin
            r_state <= GRANT1;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT0: begin
          if (!bus.req_0) begin
            r_beat_cnt <= '0;
            r_state    <= bus.req_1 ? GRANT1 : IDLE;
          end else if (w_ack_0) begin
            if (w_beat_last) begin
              r_beat_cnt <= '0;
              r_state    <= bus.req_1 ? GRANT1 : GRANT0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end else begin
            r_beat_cnt <= r_beat_cnt;
          end
        end
        GRANT1: begin
          if (!bus.req_1) begin
            r_beat_cnt <= '0;
            r_state    <= bus.req_0 ? GRANT0 : IDLE;
          end else if (w_ack_1) begin
            if (w_beat_last) begin
              r_beat_cnt <= '0;
              r_state    <= bus.req_0 ? GRANT0 : GRANT1;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end else begin
            r_beat_cnt <= r_beat_cnt;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed bench for mux21_arbiter: a cycle-by-cycle vector table plus a burst-cap sequence.
module tb_mux21_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mux21_arbiter_if #(.WIDTH(4)) bus ();

  mux21_arbiter #(.WIDTH(4), .BURST_MAX(4), .CNT_W(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       r0;
    logic [3:0] d0;
    logic       r1;
    logic [3:0] d1;
    logic       rdy;
    logic       a0;
    logic       a1;
    logic       sel;
    logic [3:0] o;
    logic       src;
    logic       v;
  } vec_t;

  vec_t vec [0:47];
  int   nvec;

  task automatic add(input int rst_i, input int r0, input int d0, input int r1, input int d1,
                     input int rdy, input int a0, input int a1, input int sel, input int o,
                     input int src, input int v);
    vec[nvec].rst = rst_i[0];
    vec[nvec].r0  = r0[0];
    vec[nvec].d0  = d0[3:0];
    vec[nvec].r1  = r1[0];
    vec[nvec].d1  = d1[3:0];
    vec[nvec].rdy = rdy[0];
    vec[nvec].a0  = a0[0];
    vec[nvec].a1  = a1[0];
    vec[nvec].sel = sel[0];
    vec[nvec].o   = o[3:0];
    vec[nvec].src = src[0];
    vec[nvec].v   = v[0];
    nvec++;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    bit got;
    total = 0;
    bad   = 0;
    nvec  = 0;

    // rst r0 d0 r1 d1 rdy | ack0 ack1 sel out src valid
    add(1, 0,  0, 0,  0, 1,  0, 0, 0,  0, 0, 0);
    add(0, 1, 12, 0,  0, 1,  0, 0, 0,  0, 0, 0);
    add(0, 1, 12, 0,  0, 1,  1, 0, 0,  0, 0, 0);
    add(0, 0,  0, 0,  0, 1,  0, 0, 0, 12, 0, 1);
    add(0, 0,  0, 0,  0, 1,  0, 0, 0, 12, 0, 0);
    // reset with both requests up: no ack while reset
    add(1, 1, 12, 1, 10, 1,  0, 0, 0, 12, 0, 0);
    add(0, 1, 12, 1, 10, 1,  0, 0, 0,  0, 0, 0);
    add(0, 1, 12, 1, 10, 1,  1, 0, 0,  0, 0, 0);
    add(0, 1, 12, 1, 10, 1,  1, 0, 0, 12, 0, 1);
    add(0, 1, 12, 1, 10, 1,  1, 0, 0, 12, 0, 1);
    add(0, 1, 12, 1, 10, 1,  1, 0, 0, 12, 0, 1);
    add(0, 1, 12, 1, 10, 1,  0, 1, 1, 12, 0, 1);
    add(0, 1, 12, 1, 10, 1,  0, 1, 1, 10, 1, 1);
    add(0, 1, 12, 1, 10, 1,  0, 1, 1, 10, 1, 1);
    add(0, 1, 12, 1, 10, 1,  0, 1, 1, 10, 1, 1);
    add(0, 1, 12, 1, 10, 1,  1, 0, 0, 10, 1, 1);
    add(0, 1, 12, 1, 10, 1,  1, 0, 0, 12, 0, 1);
    // requester 0 drops mid-burst: hand over to 1
    add(0, 0,  0, 1, 10, 1,  0, 0, 0, 12, 0, 1);
    add(0, 0,  0, 1, 10, 1,  0, 1, 1, 12, 0, 0);
    // backpressure for 5 cycles in GRANT1
    add(0, 0,  0, 1, 10, 0,  0, 0, 1, 10, 1, 1);
    add(0, 0,  0, 1, 10, 0,  0, 0, 1, 10, 1, 1);
    add(0, 0,  0, 1, 10, 0,  0, 0, 1, 10, 1, 1);
    add(0, 0,  0, 1, 10, 0,  0, 0, 1, 10, 1, 1);
    add(0, 0,  0, 1, 10, 0,  0, 0, 1, 10, 1, 1);
    add(0, 0,  0, 1,  5, 1,  0, 1, 1, 10, 1, 1);
    // reset pulse in GRANT1 with a held word
    add(1, 0,  0, 1,  5, 1,  0, 0, 1,  5, 1, 1);
    add(0, 0,  0, 0,  0, 1,  0, 0, 0,  0, 0, 0);
    // tie-break: first tie to 0, second tie depends on build
    add(0, 1,  3, 1,  9, 1,  0, 0, 0,  0, 0, 0);
    add(0, 1,  3, 1,  9, 1,  1, 0, 0,  0, 0, 0);
    add(0, 0,  0, 0,  0, 1,  0, 0, 0,  3, 0, 1);
    add(0, 1,  3, 1,  9, 1,  0, 0, 0,  3, 0, 0);
`ifdef MUX21_ARB_FIXED_PRIO_EN
    add(0, 1,  3, 1,  9, 1,  1, 0, 0,  3, 0, 0);
    add(0, 0,  0, 0,  0, 1,  0, 0, 0,  3, 0, 1);
`else
    add(0, 1,  3, 1,  9, 1,  0, 1, 1,  3, 0, 0);
    add(0, 0,  0, 0,  0, 1,  0, 0, 1,  9, 1, 1);
`endif
    add(0, 0,  0, 0,  0, 1,  0, 0, 0, 4'(`ifdef MUX21_ARB_FIXED_PRIO_EN 3 `else 9 `endif),
        `ifdef MUX21_ARB_FIXED_PRIO_EN 0 `else 1 `endif, 0);

    rst = 1'b1;
    bus.req_0 = 1'b0; bus.datain_0 = 4'd0;
    bus.req_1 = 1'b0; bus.datain_1 = 4'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      rst           = vec[i].rst;
      bus.req_0     = vec[i].r0;
      bus.datain_0  = vec[i].d0;
      bus.req_1     = vec[i].r1;
      bus.datain_1  = vec[i].d1;
      bus.out_ready = vec[i].rdy;
      #1;
      chk("ack_0",     i, 8'(bus.ack_0),     8'(vec[i].a0));
      chk("ack_1",     i, 8'(bus.ack_1),     8'(vec[i].a1));
      chk("select",    i, 8'(bus.select),    8'(vec[i].sel));
      chk("out",       i, 8'(bus.out),       8'(vec[i].o));
      chk("out_src",   i, 8'(bus.out_src),   8'(vec[i].src));
      chk("out_valid", i, 8'(bus.out_valid), 8'(vec[i].v));
    end

    // lone requester keeps streaming past BURST_MAX with no gaps
    @(negedge clk);
    bus.req_1    = 1'b1;
    bus.datain_1 = 4'd7;
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (bus.ack_1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("first_ack_1_wait", 0, 8'(got), 8'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.datain_1 = 4'(i + 1);
      #1;
      chk("stream_ack_1", i, 8'(bus.ack_1), 8'd1);
      chk("stream_out",   i, 8'(bus.out),   (i == 0) ? 8'd7 : 8'(i));
    end
    @(negedge clk);
    bus.req_1 = 1'b0;
    #1;
    chk("stream_last_out", 0, 8'(bus.out),       8'd6);
    chk("stream_last_src", 0, 8'(bus.out_src),   8'd1);
    chk("stream_last_vld", 0, 8'(bus.out_valid), 8'd1);
    chk("stream_drop_ack", 0, 8'(bus.ack_1),     8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
